// File: rtl/conv_pool_collect.sv
// conv_pool_collect
// Output-side collector for the binary conv/pool channel array. Pixel vectors
// arrive one per pooled window position in raster order (x fastest) and are
// stored as [c][r][x]. A complete map is then drained channel-major, one OUT_W
// bit row per beat (r fastest), performing the position-major to
// channel-major corner turn.
//
// Build option: define CONV_COLLECT_PINGPONG_EN for a two-bank buffer, so the
// next frame can fill while the previous one drains. Without it a single
// bank alternates strictly between FILL and DRAIN.
//
// out_valid, out_data and out_last are decoded only from registered state
// (FSM / bank flags, drain counters, buffer), never from out_ready or in_valid.

module conv_pool_collect #(
    parameter int CHAN_OUT = 18,
    parameter int OUT_H    = 4,
    parameter int OUT_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [0:CHAN_OUT-1] in_pixel,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_last
);

    localparam int CW = (CHAN_OUT > 1) ? $clog2(CHAN_OUT) : 1;
    localparam int RW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int XW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    localparam logic [CW-1:0] C_LAST = CW'(CHAN_OUT - 1);
    localparam logic [RW-1:0] R_LAST = RW'(OUT_H - 1);
    localparam logic [XW-1:0] X_LAST = XW'(OUT_W - 1);

    // Write-side raster counters
    logic [XW-1:0] wr_x_r;
    logic [RW-1:0] wr_y_r;
    // Drain-side counters
    logic [CW-1:0] rd_c_r;
    logic [RW-1:0] rd_r_r;

    // Handshake qualifiers
    logic in_ready_s;
    logic out_valid_s;
    logic wr_fire_s;
    logic wr_end_s;
    logic rd_fire_s;
    logic rd_end_s;
    logic rd_at_last_s;

    logic [OUT_W-1:0] out_data_s;
    logic             out_last_s;

    assign wr_fire_s    = in_valid && in_ready_s;
    assign wr_end_s     = wr_fire_s && (wr_x_r == X_LAST) && (wr_y_r == R_LAST);
    assign rd_at_last_s = (rd_c_r == C_LAST) && (rd_r_r == R_LAST);
    assign rd_fire_s    = out_valid_s && out_ready;
    assign rd_end_s     = rd_fire_s && rd_at_last_s;

`ifdef CONV_COLLECT_PINGPONG_EN

    // Two banks; full_r[b] marks a completely written, not yet drained frame.
    logic [OUT_W-1:0] mem_r [2][CHAN_OUT][OUT_H];
    logic [1:0]       full_r;
    logic [1:0]       full_nxt_s;
    logic             wr_bank_r;
    logic             wr_bank_nxt_s;
    logic             rd_bank_r;
    logic             rd_bank_nxt_s;

    // Bank-state register: full flags and fill/drain bank pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r    <= 2'b00;
            wr_bank_r <= 1'b0;
            rd_bank_r <= 1'b0;
        end else begin
            full_r    <= full_nxt_s;
            wr_bank_r <= wr_bank_nxt_s;
            rd_bank_r <= rd_bank_nxt_s;
        end
    end

    // Next bank state: completed fill marks its bank full, completed drain frees its bank
    always_comb begin
        full_nxt_s    = full_r;
        wr_bank_nxt_s = wr_bank_r;
        rd_bank_nxt_s = rd_bank_r;
        if (wr_end_s) begin
            full_nxt_s[wr_bank_r] = 1'b1;
            wr_bank_nxt_s         = ~wr_bank_r;
        end else begin
            wr_bank_nxt_s = wr_bank_r;
        end
        if (rd_end_s) begin
            full_nxt_s[rd_bank_r] = 1'b0;
            rd_bank_nxt_s         = ~rd_bank_r;
        end else begin
            rd_bank_nxt_s = rd_bank_r;
        end
    end

    // Handshake decode: accept while the fill bank is free, present while the drain bank is full
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        if (rst) begin
            in_ready_s  = 1'b0;
            out_valid_s = full_r[rd_bank_r];
        end else begin
            in_ready_s  = ~full_r[wr_bank_r];
            out_valid_s = full_r[rd_bank_r];
        end
    end

    // Buffer write of one pixel vector across all channels (contents not reset)
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            for (int c = 0; c < CHAN_OUT; c++) begin
                mem_r[wr_bank_r][c][wr_y_r][wr_x_r] <= in_pixel[c];
            end
        end
    end

    // Drain row selection from the bank being drained
    always_comb begin
        out_data_s = {OUT_W{1'b0}};
        out_last_s = 1'b0;
        if (out_valid_s) begin
            out_data_s = mem_r[rd_bank_r][rd_c_r][rd_r_r];
            out_last_s = rd_at_last_s;
        end else begin
            out_data_s = {OUT_W{1'b0}};
            out_last_s = 1'b0;
        end
    end

`else

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    logic [OUT_W-1:0] mem_r [CHAN_OUT][OUT_H];
    state_t           state_r;
    state_t           state_nxt_s;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FILL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: last pixel of the map starts the drain, last beat returns to fill
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_FILL: begin
                if (wr_end_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (rd_end_s) begin
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_FILL;
            end
        endcase
    end

    // FSM outputs: in_ready only in FILL (and never during reset), out_valid only in DRAIN
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            ST_FILL: begin
                in_ready_s  = ~rst;
                out_valid_s = 1'b0;
            end
            ST_DRAIN: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b1;
            end
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Buffer write of one pixel vector across all channels (contents not reset)
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            for (int c = 0; c < CHAN_OUT; c++) begin
                mem_r[c][wr_y_r][wr_x_r] <= in_pixel[c];
            end
        end
    end

    // Drain row selection; zero whenever no beat is presented
    always_comb begin
        out_data_s = {OUT_W{1'b0}};
        out_last_s = 1'b0;
        if (out_valid_s) begin
            out_data_s = mem_r[rd_c_r][rd_r_r];
            out_last_s = rd_at_last_s;
        end else begin
            out_data_s = {OUT_W{1'b0}};
            out_last_s = 1'b0;
        end
    end

`endif

    // Write counters: raster order, x fastest, both wrap after the final position
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_x_r <= {XW{1'b0}};
            wr_y_r <= {RW{1'b0}};
        end else if (wr_fire_s) begin
            if (wr_x_r == X_LAST) begin
                wr_x_r <= {XW{1'b0}};
                if (wr_y_r == R_LAST) begin
                    wr_y_r <= {RW{1'b0}};
                end else begin
                    wr_y_r <= wr_y_r + RW'(1);
                end
            end else begin
                wr_x_r <= wr_x_r + XW'(1);
            end
        end else begin
            wr_x_r <= wr_x_r;
            wr_y_r <= wr_y_r;
        end
    end

    // Drain counters: row fastest, channel slowest, both wrap after the last beat
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_c_r <= {CW{1'b0}};
            rd_r_r <= {RW{1'b0}};
        end else if (rd_fire_s) begin
            if (rd_r_r == R_LAST) begin
                rd_r_r <= {RW{1'b0}};
                if (rd_c_r == C_LAST) begin
                    rd_c_r <= {CW{1'b0}};
                end else begin
                    rd_c_r <= rd_c_r + CW'(1);
                end
            end else begin
                rd_r_r <= rd_r_r + RW'(1);
            end
        end else begin
            rd_c_r <= rd_c_r;
            rd_r_r <= rd_r_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_data  = out_data_s;
    assign out_last  = out_last_s;

endmodule

// File: tb/tb_conv_pool_collect.sv
// Testbench for conv_pool_collect. A frame-level reference model turns every
// 16 accepted pixel vectors into the 72 expected {last,row} beats (queue);
// readiness and validity follow from how many undrained frames the model holds.
// A negedge compare process checks the DUT every cycle; a few literal checks
// pin the model on hand-computed frames.

module tb_conv_pool_collect;

    localparam int CHAN_OUT = 18;
    localparam int OUT_H    = 4;
    localparam int OUT_W    = 4;
    localparam int NPOS     = OUT_H * OUT_W;
    localparam int NBEAT    = CHAN_OUT * OUT_H;
`ifdef CONV_COLLECT_PINGPONG_EN
    localparam int FRAME_LIMIT = 2;
`else
    localparam int FRAME_LIMIT = 1;
`endif

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [0:CHAN_OUT-1] in_pixel;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_W-1:0]    out_data;
    logic                out_last;

    conv_pool_collect #(.CHAN_OUT(CHAN_OUT), .OUT_H(OUT_H), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rmode  = 0;

    logic [OUT_W:0]      exp_q [$];   // {last, row}
    logic [0:CHAN_OUT-1] pix_q [$];
    logic [OUT_W-1:0]    obs   [$];   // accepted beats, for literal checks
    logic [OUT_W-1:0]    row_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pending_frames();
        return (exp_q.size() + NBEAT - 1) / NBEAT;
    endfunction

    // Reference model: frame-level accept/drain bookkeeping on each rising edge
    always @(posedge clk) begin
        bit m_valid, m_ready;
        m_valid = (exp_q.size() > 0);
        m_ready = !rst && (pending_frames() < FRAME_LIMIT);
        if (rst) begin
            exp_q.delete();
            pix_q.delete();
        end else begin
            if (m_valid && out_ready) void'(exp_q.pop_front());
            if (in_valid && m_ready) begin
                pix_q.push_back(in_pixel);
                if (pix_q.size() == NPOS) begin
                    for (int c = 0; c < CHAN_OUT; c++) begin
                        for (int r = 0; r < OUT_H; r++) begin
                            row_m = '0;
                            for (int x = 0; x < OUT_W; x++) row_m[x] = pix_q[r*OUT_W + x][c];
                            exp_q.push_back({(c == CHAN_OUT-1) && (r == OUT_H-1), row_m});
                        end
                    end
                    pix_q.delete();
                end
            end
        end
    end

    // Compare process: every falling edge, DUT outputs against the model
    always @(negedge clk) begin
        chk("in_ready", {31'd0, in_ready}, {31'd0, !rst && (pending_frames() < FRAME_LIMIT)});
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
        if (exp_q.size() > 0) begin
            chk("out_data", {28'd0, out_data}, {28'd0, exp_q[0][OUT_W-1:0]});
            chk("out_last", {31'd0, out_last}, {31'd0, exp_q[0][OUT_W]});
            if (out_ready && !rst) obs.push_back(out_data);
        end
    end

    // out_ready driver: always-on, 1,0,0,1 pattern, or random
    initial begin
        int ph;
        ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            ph++;
            case (rmode)
                1:       out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #2;
            in_pixel = CHAN_OUT'($urandom());
        end
    endtask

    task automatic send(input logic [0:CHAN_OUT-1] p, output int waited);
        logic rdy;
        waited = 0;
        in_valid = 1'b1;
        in_pixel = p;
        forever begin
            @(negedge clk) rdy = in_ready;
            @(posedge clk); #2;
            if (rdy) break;
            waited++;
            if (waited > 400) begin
                errors++;
                $display("FAIL send_timeout: waited %0d cycles, limit 400", waited);
                break;
            end
        end
        in_valid = 1'b0;
        in_pixel = CHAN_OUT'($urandom());
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        in_valid = 1'b0;
        idle(n);
        rst = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 1000) begin
            idle(1);
            n++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats left, expected 0", exp_q.size());
        end
        idle(1);
    endtask

    task automatic check_onehot_obs(input string tag);
        int nz;
        nz = 0;
        foreach (obs[i]) if (obs[i] != 4'h0) nz++;
        chk({tag, "_count"}, obs.size(), 32'd72);
        if (obs.size() == 72) begin
            chk({tag, "_c0r0"}, {28'd0, obs[0]}, 32'h1);
            chk({tag, "_c5r1"}, {28'd0, obs[21]}, 32'h2);
            chk({tag, "_c15r3"}, {28'd0, obs[63]}, 32'h8);
            chk({tag, "_c17r3"}, {28'd0, obs[71]}, 32'h0);
        end
        chk({tag, "_nonzero"}, nz, 32'd16);
    endtask

    initial begin
        int w;
        int nf;
        logic [0:CHAN_OUT-1] p;
        rst = 1'b1;
        in_valid = 1'b0;
        in_pixel = '0;
        idle(3);
        rst = 1'b0;

        // Reset state, first cycle after release
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_out_data", {28'd0, out_data}, 32'd0);
        @(posedge clk); #2;

        // One-hot frame, out_ready held high
        obs.delete();
        for (int i = 0; i < NPOS; i++) begin
            p = '0; p[i % CHAN_OUT] = 1'b1;
            send(p, w);
        end
        wait_drain();
        check_onehot_obs("onehot");

        // Same frame, out_ready toggling 1,0,0,1
        rmode = 1;
        obs.delete();
        for (int i = 0; i < NPOS; i++) begin
            p = '0; p[i % CHAN_OUT] = 1'b1;
            send(p, w);
        end
        wait_drain();
        check_onehot_obs("stall");
        rmode = 0;

        // 17th pixel presented during the drain waits for the next frame
        for (int i = 0; i < NPOS; i++) send(CHAN_OUT'($urandom()), w);
        send(CHAN_OUT'($urandom()), w);
`ifndef CONV_COLLECT_PINGPONG_EN
        chk("held_pixel_wait", w, 32'd72);
`endif
        for (int i = 1; i < NPOS; i++) send(CHAN_OUT'($urandom()), w);
        wait_drain();

        // Reset after 7 accepts, then an all-ones frame
        for (int i = 0; i < 7; i++) send(CHAN_OUT'($urandom()), w);
        do_reset(2);
        obs.delete();
        for (int i = 0; i < NPOS; i++) send({CHAN_OUT{1'b1}}, w);
        wait_drain();
        nf = 0;
        foreach (obs[i]) if (obs[i] == 4'hF) nf++;
        chk("ones_count", obs.size(), 32'd72);
        chk("ones_all_f", nf, 32'd72);

        // Bit order: channel 5 at (r=2, x=3) only
        obs.delete();
        for (int i = 0; i < NPOS; i++) begin
            p = '0;
            if (i == 2*OUT_W + 3) p[5] = 1'b1;
            send(p, w);
        end
        wait_drain();
        nf = 0;
        foreach (obs[i]) if (obs[i] != 4'h0) nf++;
        chk("bitord_nonzero", nf, 32'd1);
        if (obs.size() == 72) chk("bitord_c5r2", {28'd0, obs[22]}, 32'h8);

        // Back-to-back frames A (ones) and B (zeros)
        for (int i = 0; i < NPOS; i++) send({CHAN_OUT{1'b1}}, w);
        for (int i = 0; i < NPOS; i++) send({CHAN_OUT{1'b0}}, w);
        wait_drain();

        // Reset in the middle of a drain
        for (int i = 0; i < NPOS; i++) send(CHAN_OUT'($urandom()), w);
        idle(20);
        do_reset(1);
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #2;

        // Random frames with random gaps and random backpressure
        rmode = 2;
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < NPOS; i++) begin
                idle($urandom_range(0, 2));
                send(CHAN_OUT'($urandom()), w);
            end
        end
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
